// File: rtl/sigma_pkg.sv
// sigma_pkg: shared types and constants for the sigma multi-cycle control path.
//   state_e        5-bit FSM state encoding (FETCH=0 .. BRANCH=10)
//   OPCODE_*       RV32I major opcodes recognised by the decoder
//   ALU_OP_TYPE_*  class of operation handed to the downstream ALU control
//   IMM_TYPE_*     immediate format select for the immediate generator
//   ALU_SRC_*, MEM_TO_REG_*  datapath mux selects
package sigma_pkg;

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_MEM_ADDR  = 5'd2,
    S_MEM_READ  = 5'd3,
    S_WB_MEM    = 5'd4,
    S_MEM_WRITE = 5'd5,
    S_EXEC_R    = 5'd6,
    S_WB_R      = 5'd7,
    S_EXEC_I    = 5'd8,
    S_WB_I      = 5'd9,
    S_BRANCH    = 5'd10
  } state_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;

  localparam logic [1:0] ALU_OP_TYPE_LSU = 2'b00;  // address add
  localparam logic [1:0] ALU_OP_TYPE_LUI = 2'b01;  // pass upper immediate
  localparam logic [1:0] ALU_OP_TYPE_R_I = 2'b10;  // decode funct3/funct7
  localparam logic [1:0] ALU_OP_TYPE_BR  = 2'b11;  // SUB for branch compare

  localparam logic [2:0] IMM_TYPE_I = 3'd0;
  localparam logic [2:0] IMM_TYPE_S = 3'd1;
  localparam logic [2:0] IMM_TYPE_B = 3'd2;
  localparam logic [2:0] IMM_TYPE_U = 3'd3;
  localparam logic [2:0] IMM_TYPE_J = 3'd4;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  localparam logic MEM_TO_REG_ALU_RES  = 1'b0;
  localparam logic MEM_TO_REG_MEM_DATA = 1'b1;

endpackage

// File: rtl/sigma_instret_ctr.sv
// sigma_instret_ctr: 32-bit retired-instruction counter, wraps at 2^32.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   inc_i     count one retirement at the next edge
//   count_o   current count; reads 0 while rst is high
module sigma_instret_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb cnt_d = inc_i ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Reset is visible on the output in the cycle it is raised.
  assign count_o = rst ? '0 : cnt_q;

endmodule

// File: rtl/sigma_mc_control.sv
// sigma_mc_control: multi-cycle RV32I control FSM (LOAD/STORE/R/IMM/LUI/BEQ).
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7 instruction fields from the IR (funct7 unused here)
//   alu_zero            ALU result is zero (branch compare)
//   mem_ready           memory completes the current access this cycle
//   mem_req/mem_we/iord memory strobes and address select (0 PC, 1 ALU reg)
//   ir_write/pc_write/pc_src, reg_write, alu_src, mem_to_reg, alu_op, imm_type
//                       datapath controls, Moore decode of state
//   illegal_instr       one-cycle pulse in DECODE on an unsupported opcode
//   state_o             current state, instret  retired-instruction count
// Build option: define SIGMA_BRANCH_EN to support BEQ; otherwise the BRANCH
// opcode is treated as illegal.
module sigma_mc_control
  import sigma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_type,
  output logic        illegal_instr,
  output logic [4:0]  state_o,
  output logic [31:0] instret
);

  state_e state_q, state_d;
  logic   retire;

  // funct3/alu_zero are only consumed when branches are built in.
  logic unused_ok;
  assign unused_ok = ^{funct7, funct3, alu_zero};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    alu_src       = ALU_SRC_REG;
    mem_to_reg    = MEM_TO_REG_ALU_RES;
    alu_op        = ALU_OP_TYPE_LSU;
    imm_type      = IMM_TYPE_I;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    // Reset suppresses every strobe immediately, even mid-wait.
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (opcode)
            OPCODE_LOAD, OPCODE_STORE: state_d = S_MEM_ADDR;
            OPCODE_RTYPE:              state_d = S_EXEC_R;
            OPCODE_IMM, OPCODE_LUI:    state_d = S_EXEC_I;
`ifdef SIGMA_BRANCH_EN
            OPCODE_BRANCH:             state_d = S_BRANCH;
`endif
            default: begin
              illegal_instr = 1'b1;
              state_d       = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src = ALU_SRC_IMM;
          if (opcode == OPCODE_STORE) begin
            imm_type = IMM_TYPE_S;
            state_d  = S_MEM_WRITE;
          end else begin
            state_d  = S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_WB_MEM;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = MEM_TO_REG_MEM_DATA;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_op  = ALU_OP_TYPE_R_I;
          state_d = S_WB_R;
        end
        S_EXEC_I: begin
          alu_src = ALU_SRC_IMM;
          if (opcode == OPCODE_LUI) begin
            alu_op   = ALU_OP_TYPE_LUI;
            imm_type = IMM_TYPE_U;
          end else begin
            alu_op   = ALU_OP_TYPE_R_I;
          end
          state_d = S_WB_I;
        end
        S_WB_R, S_WB_I: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
`ifdef SIGMA_BRANCH_EN
        S_BRANCH: begin
          alu_op   = ALU_OP_TYPE_BR;
          imm_type = IMM_TYPE_B;
          pc_src   = 1'b1;
          // Only BEQ is implemented; other compares fall through untaken.
          pc_write = alu_zero && (funct3 == FUNCT3_BEQ);
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state_o = rst ? S_FETCH : state_q;

  sigma_instret_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire),
    .count_o (instret)
  );

endmodule

// File: tb/tb_sigma_mc_control.sv
module tb_sigma_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
  logic        alu_src, mem_to_reg, illegal_instr;
  logic [1:0]  alu_op;
  logic [2:0]  imm_type;
  logic [4:0]  state_o;
  logic [31:0] instret;

  always #5 clk = ~clk;

  sigma_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .imm_type(imm_type), .illegal_instr(illegal_instr),
    .state_o(state_o), .instret(instret)
  );

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4,
                 K_BEQ = 5, K_BNE = 6, K_ILL = 7;

`ifdef SIGMA_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_instret;
  // Observations from the most recent instruction, for directed checks.
  logic [4:0]  st_tr[$];
  int          rw_at, brpw_at, ill_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from its first FETCH cycle. wf = fetch wait cycles,
  // wd = data-access wait cycles, z = alu_zero. Expectations come from the
  // instruction-level rules: latency, strobe counts and retirement.
  task automatic run_instr(input int kind, input int wf, input int wd, input bit z);
    int base, L, dstart;
    bit mem, ill, br, taken;
    int c_req, c_we, c_ir, c_pw, c_br, c_rw, c_m2r, c_ill, c_iord;
    logic [7:0] imm_set, aop_set, exp_imm, exp_aop;
    mem = 0; ill = 0; br = 0; taken = 0;
    funct3 = 3'd0;
    case (kind)
      K_R:   begin opcode = 7'h33; base = 4; end
      K_I:   begin opcode = 7'h13; base = 4; end
      K_LUI: begin opcode = 7'h37; base = 4; end
      K_LW:  begin opcode = 7'h03; funct3 = 3'd2; base = 5; mem = 1; end
      K_SW:  begin opcode = 7'h23; funct3 = 3'd2; base = 4; mem = 1; end
      K_BEQ: begin opcode = 7'h63; base = 3; br = 1; end
      K_BNE: begin opcode = 7'h63; funct3 = 3'd1; base = 3; br = 1; end
      default: begin opcode = 7'h7F; ill = 1; base = 2; end
    endcase
    if (br && !BR_EN) begin ill = 1; base = 2; end
    taken  = br && !ill && kind == K_BEQ && z;
    L      = base + wf + (mem ? wd : 0);
    dstart = wf + 3;
    funct7 = 7'($urandom);
    alu_zero = z;
    c_req = 0; c_we = 0; c_ir = 0; c_pw = 0; c_br = 0; c_rw = 0; c_m2r = 0;
    c_ill = 0; c_iord = 0; imm_set = 0; aop_set = 0;
    st_tr.delete(); rw_at = -1; brpw_at = -1; ill_st = -1;
    for (int k = 0; k < L; k++) begin
      if (k <= wf)                               mem_ready = (k == wf);
      else if (mem && k >= dstart && k <= dstart + wd) mem_ready = (k == dstart + wd);
      else                                        mem_ready = 1'($urandom);
      @(negedge clk);
      st_tr.push_back(state_o);
      c_req  += mem_req;  c_we += mem_we;  c_ir += ir_write;  c_pw += pc_write;
      c_iord += (mem_req && iord);
      if (pc_write && pc_src) begin c_br++; brpw_at = k; end
      if (reg_write) begin c_rw++; rw_at = k; c_m2r += mem_to_reg; end
      if (illegal_instr) begin c_ill++; ill_st = state_o; end
      imm_set[imm_type] = 1'b1;
      aop_set[alu_op]   = 1'b1;
      @(posedge clk); #1;
    end
    exp_imm = 8'h01; exp_aop = 8'h01;
    if (!ill) begin
      case (kind)
        K_SW:         exp_imm[1] = 1'b1;
        K_LUI:        begin exp_imm[3] = 1'b1; exp_aop[1] = 1'b1; end
        K_R, K_I:     exp_aop[2] = 1'b1;
        K_BEQ, K_BNE: begin exp_imm[2] = 1'b1; exp_aop[3] = 1'b1; end
        default: ;
      endcase
    end
    if (!ill) exp_instret = exp_instret + 32'd1;
    chk("end_state", state_o, 0);
    chk("mem_req_cyc", c_req, wf + 1 + (mem ? wd + 1 : 0));
    chk("iord_cyc", c_iord, mem ? wd + 1 : 0);
    chk("mem_we_cyc", c_we, kind == K_SW ? wd + 1 : 0);
    chk("ir_write", c_ir, 1);
    chk("pc_write", c_pw, 1 + taken);
    chk("pc_br", c_br, taken);
    chk("reg_write", c_rw, (!ill && kind inside {K_R, K_I, K_LUI, K_LW}) ? 1 : 0);
    chk("mem_to_reg", c_m2r, kind == K_LW ? 1 : 0);
    chk("illegal", c_ill, ill);
    chk("imm_types", imm_set, exp_imm);
    chk("alu_ops", aop_set, exp_aop);
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    int kind;
    rst = 1'b1; opcode = 7'h33; funct3 = 0; funct7 = 0; alu_zero = 0; mem_ready = 1;
    exp_instret = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_instret", instret, 0);
    chk("rst_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write, illegal_instr}, 0);
    rst = 1'b0;

    // ADD x3,x1,x2
    run_instr(K_R, 0, 0, 0);
    chk("add_len", st_tr.size(), 4);
    chk("add_s0", st_tr[0], 0); chk("add_s1", st_tr[1], 1);
    chk("add_s2", st_tr[2], 6); chk("add_s3", st_tr[3], 7);
    chk("add_rw_cycle", rw_at, 3);

    // LW with two wait cycles in MEM_READ
    run_instr(K_LW, 0, 2, 0);
    chk("lw_len", st_tr.size(), 7);

    // BEQ taken / untaken
    run_instr(K_BEQ, 0, 0, 1);
    chk("beq_pw_cycle", brpw_at, BR_EN ? 2 : -1);
    run_instr(K_BEQ, 0, 0, 0);
    chk("beq_nt_pw", brpw_at, -1);

    // Illegal opcode 0x7F pulses in DECODE
    run_instr(K_ILL, 1, 0, 0);
    chk("ill_state", ill_st, 1);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Counter wrap: preload all-ones, then retire a store
    force dut.u_ctr.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_ctr.cnt_q;
    exp_instret = 32'hFFFF_FFFF;
    chk("preload", instret, 32'hFFFF_FFFF);
    run_instr(K_SW, 0, 1, 0);
    chk("wrap", instret, 0);

    // Reset during a MEM_WRITE wait
    opcode = 7'h23; funct3 = 3'd2; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("mw_state", state_o, 5);
    chk("mw_we", mem_we, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mw_we", mem_we, 0);
    chk("rst_mw_req", mem_req, 0);
    chk("rst_mw_state", state_o, 0);
    chk("rst_mw_instret", instret, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 0;
    chk("post_rst_state", state_o, 0);
    run_instr(K_R, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
